// File: rtl/image_stream_loader_pkg.sv
// ============================================================================
// Module  : image_stream_loader_pkg
// Brief   : Shared constants and state encoding for the image stream loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package image_stream_loader_pkg;

  localparam int NUM_IMAGES = 1797;
  localparam int IMAGE_SIZE = 65;
  localparam int ADDR_WIDTH = 17;
  localparam int DATA_WIDTH = 16;
  localparam int IDX_WIDTH  = 11;
  localparam int CNT_WIDTH  = 7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FETCH = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/image_stream_loader_if.sv
// ============================================================================
// Module  : image_stream_loader_if
// Brief   : Pixel stream valid/ready bundle between loader and consumer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface image_stream_loader_if #(
  parameter int DATA_WIDTH = image_stream_loader_pkg::DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] pix_data;
  logic                  pix_valid;
  logic                  pix_ready;
  logic                  pix_last;

  modport master (output pix_data, output pix_valid, output pix_last, input pix_ready);
  modport slave  (input pix_data, input pix_valid, input pix_last, output pix_ready);
endinterface

`default_nettype wire

// File: rtl/image_stream_loader_skid.sv
// ============================================================================
// Module  : stream_skid_buffer
// Brief   : 2-entry FIFO with registered head; absorbs the ROM read latency so
//           the stream can run one word per cycle under backpressure.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_skid_buffer #(
  parameter int WIDTH = 17
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] push_data,
  input  wire logic             pop,
  output logic      [WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic      [1:0]       occ
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       occ_q;

  // Head always holds the oldest entry; tail holds the second when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) head_q <= push_data;
          else               tail_q <= push_data;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; at occ=1 the new word replaces the head.
          if (occ_q == 2'd1) begin
            head_q <= push_data;
          end else begin
            head_q <= tail_q;
            tail_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data  = head_q;
  assign out_valid = (occ_q != 2'd0);
  assign occ       = occ_q;

endmodule

`default_nettype wire

// File: rtl/image_stream_loader.sv
// ============================================================================
// Module  : image_stream_loader
// Brief   : Reads one image record from ROM, streams its pixels over
//           valid/ready and returns the trailing word as the class label.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module image_stream_loader
  import image_stream_loader_pkg::*;
#(
  parameter int NUM_IMAGES = image_stream_loader_pkg::NUM_IMAGES,
  parameter int IMAGE_SIZE = image_stream_loader_pkg::IMAGE_SIZE,
  parameter int ADDR_WIDTH = image_stream_loader_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = image_stream_loader_pkg::DATA_WIDTH,
  parameter int IDX_WIDTH  = image_stream_loader_pkg::IDX_WIDTH
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  start,
  input  wire logic [IDX_WIDTH-1:0]  img_idx,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic                       rom_ren,
  output logic      [ADDR_WIDTH-1:0] rom_radd,
  input  wire logic [DATA_WIDTH-1:0] rom_data,
  image_stream_loader_if.master      pix,
  output logic      [DATA_WIDTH-1:0] label,
  output logic                       label_valid
);

  localparam logic [CNT_WIDTH-1:0]  CNT_END   = CNT_WIDTH'(IMAGE_SIZE);
  localparam logic [CNT_WIDTH-1:0]  CNT_LABEL = CNT_WIDTH'(IMAGE_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_LASTP = CNT_WIDTH'(IMAGE_SIZE - 2);
  localparam logic [IDX_WIDTH:0]    IDX_LIMIT = (IDX_WIDTH+1)'(NUM_IMAGES);
  localparam logic [ADDR_WIDTH-1:0] REC_WORDS = ADDR_WIDTH'(IMAGE_SIZE);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [CNT_WIDTH-1:0]    rd_cnt_q;
  logic                    pix_inflight_q;
  logic                    last_inflight_q;
  logic                    label_inflight_q;
  logic [DATA_WIDTH-1:0]   label_q;
  logic                    err_q;

  logic                    idx_legal;
  logic                    accept;
  logic                    is_label_rd;
  logic                    pop;
  logic [1:0]              occ;
  logic [2:0]              occ_after;
  logic [2:0]              credit;
  logic [DATA_WIDTH:0]     skid_out;

  assign idx_legal   = ({1'b0, img_idx} < IDX_LIMIT);
  assign accept      = (state_q == S_IDLE) && start && idx_legal;
  assign is_label_rd = (rd_cnt_q == CNT_LABEL);
  assign pop         = pix.pix_valid & pix.pix_ready;
  assign occ_after   = {1'b0, occ} - {2'b00, pop};
  assign credit      = occ_after + {2'b00, pix_inflight_q};

  // Next-state and ROM issue decision; a pixel read needs a free slot after
  // counting this cycle's pop and the word still in flight.
  always_comb begin
    state_d = state_q;
    rom_ren = 1'b0;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_LOAD;
      S_LOAD:  state_d = S_FETCH;
      S_FETCH: begin
        if ((rd_cnt_q < CNT_END) && (is_label_rd || (credit < 3'd2))) rom_ren = 1'b1;
        if (rom_ren && is_label_rd) state_d = S_DRAIN;
      end
      S_DRAIN: if ((occ_after == 3'd0) && !pix_inflight_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Address counter, in-flight tracking, label capture and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q           <= '0;
      rd_cnt_q         <= '0;
      pix_inflight_q   <= 1'b0;
      last_inflight_q  <= 1'b0;
      label_inflight_q <= 1'b0;
      label_q          <= '0;
      err_q            <= 1'b0;
    end else begin
      if (accept) base_q <= ADDR_WIDTH'(img_idx) * REC_WORDS;
      if (state_q == S_LOAD) rd_cnt_q <= '0;
      else if (rom_ren)      rd_cnt_q <= rd_cnt_q + 1'b1;
      pix_inflight_q   <= rom_ren && !is_label_rd;
      last_inflight_q  <= rom_ren && (rd_cnt_q == CNT_LASTP);
      label_inflight_q <= rom_ren && is_label_rd;
      if (label_inflight_q) label_q <= rom_data;
      err_q <= (state_q == S_IDLE) && start && !idx_legal;
    end
  end

  stream_skid_buffer #(.WIDTH(DATA_WIDTH + 1)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pix_inflight_q),
    .push_data ({last_inflight_q, rom_data}),
    .pop       (pop),
    .out_data  (skid_out),
    .out_valid (pix.pix_valid),
    .occ       (occ)
  );

  assign pix.pix_data = skid_out[DATA_WIDTH-1:0];
  assign pix.pix_last = skid_out[DATA_WIDTH];
  assign rom_radd     = base_q + ADDR_WIDTH'(rd_cnt_q);
  assign busy         = (state_q == S_LOAD) || (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done         = (state_q == S_DONE);
  assign label_valid  = (state_q == S_DONE);
  assign label        = label_q;
  assign err          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_image_stream_loader.sv
// ============================================================================
// Module  : tb_image_stream_loader
// Brief   : Directed bench for image_stream_loader with a registered ROM model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_image_stream_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] img_idx = '0;
  logic        busy, done, err, rom_ren, label_valid;
  logic [16:0] rom_radd;
  logic [15:0] rom_data = '0;
  logic [15:0] label;

  int pass_cnt = 0;
  int total_cnt = 0;

  image_stream_loader_if #(.DATA_WIDTH(16)) pif ();

  image_stream_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .img_idx     (img_idx),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .rom_ren     (rom_ren),
    .rom_radd    (rom_radd),
    .rom_data    (rom_data),
    .pix         (pif),
    .label       (label),
    .label_valid (label_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input int unsigned a);
    return 16'((a * 40503) ^ (a >> 5) ^ 32'h1234);
  endfunction

  // Registered ROM: data appears the cycle after the read enable.
  always @(posedge clk) if (rom_ren) rom_data <= rom_word(int'(rom_radd));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else pass_cnt++;
  endtask

  typedef struct {
    int idx;
    int pct;
    int exp_base;
    bit exp_err;
    bit inj_start;
  } vec_t;

  // Streams one image; when stop_pix>=0 returns right after that many pixels.
  task automatic run_image(input vec_t v, input int stop_pix);
    int c = 0, npix = 0, nreads = 0;
    int first_ren = -1, first_val = -1, last_c = -1;
    bit injected = 0, finished = 0, prev_stall = 0, prev_last = 0;
    logic [15:0] prev_data = '0;
    @(posedge clk); #1;
    start = 1'b1; img_idx = 11'(v.idx);
    @(posedge clk); #1;
    start = 1'b0;
    if (v.exp_err) begin
      @(negedge clk);
      check("err_pulse", {31'd0, err}, 32'd1);
      check("err_busy", {31'd0, busy}, 32'd0);
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); #1;
        @(negedge clk);
        check("err_no_ren", {30'd0, rom_ren, err}, 32'd0);
      end
      return;
    end
    while (!finished && c < 3000) begin
      pif.pix_ready = (($urandom % 100) < v.pct);
      if (v.inj_start && npix == 10 && !injected) begin
        start = 1'b1; img_idx = 11'd5; injected = 1;
      end
      @(negedge clk);
      c++;
      if (c == 1) check("busy_after_start", {31'd0, busy}, 32'd1);
      if (rom_ren) begin
        if (first_ren < 0) first_ren = c;
        check("rom_radd", {15'd0, rom_radd}, 32'(v.exp_base + nreads));
        nreads++;
      end
      if (pif.pix_valid && first_val < 0) first_val = c;
      if (prev_stall)
        check("stall_stable", {15'd0, pif.pix_valid, pif.pix_last, pif.pix_data},
              {15'd0, 1'b1, prev_last, prev_data});
      prev_stall = pif.pix_valid && !pif.pix_ready;
      prev_data  = pif.pix_data;
      prev_last  = pif.pix_last;
      if (pif.pix_valid && pif.pix_ready) begin
        check("pix_data", {15'd0, pif.pix_last, pif.pix_data},
              {15'd0, (npix == 63), rom_word(v.exp_base + npix)});
        if (pif.pix_last) last_c = c;
        npix++;
      end
      if (done) begin
        check("done_label", {label_valid, busy, 14'd0, label},
              {1'b1, 1'b0, 14'd0, rom_word(v.exp_base + 64)});
        check("done_counts", 32'((npix << 8) | nreads), 32'((64 << 8) | 65));
        if (v.pct == 100)
          check("timing", 32'((first_ren << 24) | (first_val << 16) | (last_c << 8) | c),
                32'((2 << 24) | (4 << 16) | (67 << 8) | 68));
        finished = 1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (stop_pix >= 0 && npix == stop_pix) return;
    end
    check("done_timeout", {31'd0, finished}, 32'd1);
    pif.pix_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("post_idle", {29'd0, done, rom_ren, pif.pix_valid}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{idx: 0,    pct: 100, exp_base: 0,      exp_err: 0, inj_start: 0};
    vecs[1] = '{idx: 1796, pct: 100, exp_base: 116740, exp_err: 0, inj_start: 0};
    vecs[2] = '{idx: 1,    pct: 30,  exp_base: 65,     exp_err: 0, inj_start: 0};
    vecs[3] = '{idx: 1797, pct: 100, exp_base: 0,      exp_err: 1, inj_start: 0};
    vecs[4] = '{idx: 3,    pct: 100, exp_base: 195,    exp_err: 0, inj_start: 1};
    vecs[5] = '{idx: 100,  pct: 30,  exp_base: 6500,   exp_err: 0, inj_start: 0};
    vecs[6] = '{idx: 2047, pct: 100, exp_base: 0,      exp_err: 1, inj_start: 0};

    pif.pix_ready = 1'b1;
    #12;
    check("reset_outputs", {busy, done, err, rom_ren, label_valid, pif.pix_valid,
                            pif.pix_last, 8'd0, rom_radd[16:0]}, 32'd0);
    check("reset_data", {pif.pix_data, label}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_ready_high", {30'd0, pif.pix_valid, busy}, 32'd0);
    end

    for (int i = 0; i < 7; i++) run_image(vecs[i], -1);

    // Reset after 20 pixels of image 9, then image 7 from its first pixel.
    run_image('{idx: 9, pct: 100, exp_base: 585, exp_err: 0, inj_start: 0}, 20);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {26'd0, busy, done, label_valid, rom_ren, pif.pix_valid,
                             pif.pix_last}, 32'd0);
    check("midrst_data", {pif.pix_data, label}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("midrst_quiet", {29'd0, done, busy, pif.pix_valid}, 32'd0);
    end
    run_image('{idx: 7, pct: 100, exp_base: 455, exp_err: 0, inj_start: 0}, -1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
